// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline boundary: a 2-entry skid buffer between the ALU and the MEM stage.
// in_ready_o is registered-state only, so MEM backpressure never forms a combinational path into EX.
module ex_mem_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              zero_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_alu_data_o,
  output logic              out_zero_o,
  output logic [DATA_W-1:0] out_rs2_data_o,
  output logic [ADDR_W-1:0] out_rd_addr_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic              zero;
    logic [DATA_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;

  state_t   state_q, state_d;
  payload_t main_q, skid_q, in_pl;
  logic     in_fire, out_fire;
  logic     ld_main_in, ld_main_skid, ld_skid;

  assign in_pl = '{alu: alu_data_i, zero: zero_i, rs2: rs2_data_i, rd: rd_addr_i, ctrl: ctrl_i};

  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          ld_main_in = 1'b1;
          state_d    = HALF;
        end
      end
      HALF: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          ld_skid = 1'b1;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          ld_main_skid = 1'b1;
          state_d      = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over every transfer; main keeps its stale fields for the gated outputs.
    if (flush_i) begin
      state_d      = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ld_main_in)        main_q <= in_pl;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_pl;
    end
  end

  assign out_alu_data_o = main_q.alu;
  assign out_zero_o     = main_q.zero;
  assign out_rs2_data_o = main_q.rs2;
  assign out_rd_addr_o  = main_q.rd;
  // Bubbles carry no control so RegWrite/MemWrite never fire on stale data.
  assign out_ctrl_o     = out_valid_o ? main_q.ctrl : '0;

  always_comb begin
    case (state_q)
      HALF:    occupancy_o = 2'd1;
      FULL:    occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid: a queue model checked every cycle plus hand-computed spot checks.
module tb_ex_mem_skid;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] alu_data_i = '0;
  logic        zero_i = 1'b0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic [3:0]  ctrl_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_alu_data_o;
  logic        out_zero_o;
  logic [31:0] out_rs2_data_o;
  logic [4:0]  out_rd_addr_o;
  logic [3:0]  out_ctrl_o;
  logic [1:0]  occupancy_o;

  ex_mem_skid #(.DATA_W(32), .ADDR_W(5), .CTRL_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_data_i(alu_data_i), .zero_i(zero_i), .rs2_data_i(rs2_data_i),
    .rd_addr_i(rd_addr_i), .ctrl_i(ctrl_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_alu_data_o(out_alu_data_o), .out_zero_o(out_zero_o),
    .out_rs2_data_o(out_rs2_data_o), .out_rd_addr_o(out_rd_addr_o),
    .out_ctrl_o(out_ctrl_o), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
  } ent_t;

  ent_t q[$];
  ent_t last;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    last = '{alu: 32'd0, zero: 1'b0, rs2: 32'd0, rd: 5'd0, ctrl: 4'd0};
  endtask

  // Queue semantics: pop the head if MEM takes it, append if there was room before the edge.
  task automatic model_edge();
    ent_t p;
    bit   inf, outf;
    p    = '{alu: alu_data_i, zero: zero_i, rs2: rs2_data_i, rd: rd_addr_i, ctrl: ctrl_i};
    inf  = in_valid_i && (q.size() < 2);
    outf = (q.size() > 0) && out_ready_i;
    if (flush_i) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf)  q.push_back(p);
    end
    if (q.size() > 0) last = q[0];
  endtask

  task automatic cyc(input bit iv, input logic [31:0] alu, input bit z, input logic [31:0] rs2,
                     input logic [4:0] rd, input logic [3:0] ctrl, input bit ordy, input bit fl);
    in_valid_i = iv; alu_data_i = alu; zero_i = z; rs2_data_i = rs2;
    rd_addr_i = rd; ctrl_i = ctrl; out_ready_i = ordy; flush_i = fl;
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic push(input logic [31:0] alu, input bit ordy);
    cyc(1'b1, alu, 1'b0, ~alu, alu[4:0], alu[3:0] | 4'b1000, ordy, 1'b0);
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 32'hBAD0_BAD0, 1'b1, 32'h0BAD_0BAD, 5'd31, 4'b1111, ordy, 1'b0);
  endtask

  // Every cycle, the DUT must match the queue model.
  always @(negedge clk_i) begin
    ent_t h;
    bit   v;
    h = last;
    v = (q.size() > 0);
    chk("out_valid", {31'd0, out_valid_o}, {31'd0, v});
    chk("in_ready", {31'd0, in_ready_o}, {31'd0, q.size() < 2});
    chk("occupancy", {30'd0, occupancy_o}, q.size());
    chk("out_ctrl", {28'd0, out_ctrl_o}, v ? {28'd0, h.ctrl} : 32'd0);
    chk("out_alu", out_alu_data_o, h.alu);
    chk("out_zero", {31'd0, out_zero_o}, {31'd0, h.zero});
    chk("out_rs2", out_rs2_data_o, h.rs2);
    chk("out_rd", {27'd0, out_rd_addr_o}, {27'd0, h.rd});
  end

  initial begin
    model_reset();
    #12;
    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst_occ", {30'd0, occupancy_o}, 32'd0);
    chk("rst_alu", out_alu_data_o, 32'd0);
    @(posedge clk_i); #1; rst_i = 1'b1;

    // streaming, one per cycle
    push(32'h0000_0005, 1'b1);
    chk("s1_alu", out_alu_data_o, 32'h5);
    chk("s1_occ", {30'd0, occupancy_o}, 32'd1);
    push(32'h0000_000A, 1'b1);
    chk("s2_alu", out_alu_data_o, 32'hA);
    chk("s2_ready", {31'd0, in_ready_o}, 32'd1);
    push(32'hFFFF_FFFF, 1'b1);
    chk("s3_alu", out_alu_data_o, 32'hFFFF_FFFF);
    chk("s3_occ", {30'd0, occupancy_o}, 32'd1);
    idle(1'b1);
    chk("s4_valid", {31'd0, out_valid_o}, 32'd0);

    // backpressure
    push(32'h11, 1'b0);
    push(32'h22, 1'b0);
    chk("bp_occ", {30'd0, occupancy_o}, 32'd2);
    chk("bp_ready", {31'd0, in_ready_o}, 32'd0);
    chk("bp_alu", out_alu_data_o, 32'h11);
    push(32'h33, 1'b0);
    chk("bp_ign_alu", out_alu_data_o, 32'h11);
    idle(1'b1);
    chk("bp_pop1", out_alu_data_o, 32'h22);
    chk("bp_pop1_rdy", {31'd0, in_ready_o}, 32'd1);
    idle(1'b1);
    chk("bp_empty", {30'd0, occupancy_o}, 32'd0);

    // flush in FULL with a concurrent input
    push(32'h11, 1'b0);
    push(32'h22, 1'b0);
    cyc(1'b1, 32'h44, 1'b0, 32'h0, 5'd4, 4'b1111, 1'b0, 1'b1);
    chk("fl_occ", {30'd0, occupancy_o}, 32'd0);
    chk("fl_valid", {31'd0, out_valid_o}, 32'd0);
    chk("fl_ctrl", {28'd0, out_ctrl_o}, 32'd0);
    idle(1'b1);
    idle(1'b1);

    // ctrl gating
    cyc(1'b1, 32'h77, 1'b0, 32'h0, 5'd7, 4'b1001, 1'b0, 1'b0);
    chk("cg_ctrl", {28'd0, out_ctrl_o}, 32'h9);
    idle(1'b1);
    chk("cg_ctrl_idle", {28'd0, out_ctrl_o}, 32'd0);
    chk("cg_rd_hold", {27'd0, out_rd_addr_o}, 32'd7);

    // zero / store pass-through, held under stall
    cyc(1'b1, 32'h0, 1'b1, 32'hDEAD_BEEF, 5'd0, 4'b1000, 1'b0, 1'b0);
    chk("pt_zero", {31'd0, out_zero_o}, 32'd1);
    chk("pt_rs2", out_rs2_data_o, 32'hDEAD_BEEF);
    idle(1'b0);
    chk("pt_hold", out_rs2_data_o, 32'hDEAD_BEEF);
    idle(1'b1);

    // streaming while a skid entry drains
    push(32'hA1, 1'b0);
    push(32'hA2, 1'b0);
    push(32'hA3, 1'b1);
    chk("dr_alu", out_alu_data_o, 32'hA2);
    push(32'hA4, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // async reset between edges while FULL
    push(32'h55, 1'b0);
    push(32'h66, 1'b0);
    #2;
    rst_i = 1'b0;
    model_reset();
    #1;
    chk("ar_valid", {31'd0, out_valid_o}, 32'd0);
    chk("ar_ready", {31'd0, in_ready_o}, 32'd1);
    chk("ar_occ", {30'd0, occupancy_o}, 32'd0);
    chk("ar_alu", out_alu_data_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    push(32'h99, 1'b1);
    chk("post_rst", out_alu_data_o, 32'h99);
    idle(1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
